// File: rtl/alarm_rtc_core.sv
// alarm_rtc_core: BCD time-of-day counter with alarm compare and interrupt,
// exposed as a 16-bit Avalon-MM slave. Advances on the 1 Hz `tick` from the
// upstream interval timer.
// Optional snooze feature: define ALARM_RTC_SNOOZE_EN to enable the SNOOZE
// register at address 5; otherwise address 5 reads 0 and ignores writes.
module alarm_rtc_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    // Time of day and alarm, all BCD
    logic [7:0] hours, minutes, seconds;
    logic [7:0] alm_hours, alm_minutes;

    // CONTROL and STATUS bits
    logic run, alarm_en, irq_en;
    logic fired, err;

`ifdef ALARM_RTC_SNOOZE_EN
    logic       snz_act;
    logic [3:0] snz_cnt;
    logic       snz_fire;
`endif

    logic       we;
    logic       wr_time;
    logic       count_en;
    logic       sec_wrap, min_wrap, hr_wrap;
    logic [7:0] next_seconds, next_minutes, next_hours;
    logic       minute_evt;
    logic       alarm_evt;
    logic [15:0] rd_mux;

    // BCD increment of a two-digit value; callers handle the wrap point
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Two BCD digits in 00..max_tens9 style range for minutes/seconds (00-59)
    function automatic logic ms_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // Hours 00-23 in [15:8], minutes 00-59 in [7:0]
    function automatic logic hm_ok(input logic [15:0] v);
        return (v[15:12] <= 4'd2) && (v[11:8] <= 4'd9) &&
               (v[15:8] <= 8'h23) && ms_ok(v[7:0]);
    endfunction

    assign we       = chipselect && !write_n;
    // A time write in the same cycle as tick wins; that tick is dropped
    assign wr_time  = we && ((address == 3'd2) || (address == 3'd3));
    assign count_en = tick && run && !wr_time;

    assign sec_wrap = (seconds == 8'h59);
    assign min_wrap = (minutes == 8'h59);
    assign hr_wrap  = (hours   == 8'h23);

    // Next time-of-day values for a counted tick, including carries
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        next_seconds = sec_wrap ? 8'h00 : bcd_inc(seconds);
        next_minutes = minutes;
        next_hours   = hours;
        if (sec_wrap) begin
            next_minutes = min_wrap ? 8'h00 : bcd_inc(minutes);
            if (min_wrap)
                next_hours = hr_wrap ? 8'h00 : bcd_inc(hours);
        end
    end

    assign minute_evt = count_en && sec_wrap;
    // Compare uses the registered alarm, so a same-cycle ALARM_HM write is not seen
    assign alarm_evt  = minute_evt && alarm_en &&
                        ({next_hours, next_minutes} == {alm_hours, alm_minutes});

`ifdef ALARM_RTC_SNOOZE_EN
    assign snz_fire = minute_evt && snz_act && (snz_cnt == 4'd1) && alarm_en;
`endif

    // Read mux feeding the registered readdata; unused bits and addresses read 0
    always_comb begin
        rd_mux = 16'h0000;
        case (address)
            3'd0: rd_mux = {13'b0, err, run, fired};
            3'd1: rd_mux = {13'b0, irq_en, alarm_en, run};
            3'd2: rd_mux = {hours, minutes};
            3'd3: rd_mux = {8'h00, seconds};
            3'd4: rd_mux = {alm_hours, alm_minutes};
`ifdef ALARM_RTC_SNOOZE_EN
            3'd5: rd_mux = {11'b0, snz_act, snz_cnt};
`endif
            default: rd_mux = 16'h0000;
        endcase
    end

    assign irq = fired && irq_en;

    // All register state: counting, bus writes, status flags and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            hours       <= 8'h00;
            minutes     <= 8'h00;
            seconds     <= 8'h00;
            alm_hours   <= 8'h00;
            alm_minutes <= 8'h00;
            run         <= 1'b0;
            alarm_en    <= 1'b0;
            irq_en      <= 1'b0;
            fired       <= 1'b0;
            err         <= 1'b0;
            readdata    <= 16'h0000;
`ifdef ALARM_RTC_SNOOZE_EN
            snz_act     <= 1'b0;
            snz_cnt     <= 4'd0;
`endif
        end else begin
            readdata <= rd_mux;

            if (count_en) begin
                seconds <= next_seconds;
                minutes <= next_minutes;
                hours   <= next_hours;
            end

`ifdef ALARM_RTC_SNOOZE_EN
            if (minute_evt && snz_act) begin
                if (snz_cnt == 4'd1) begin
                    snz_act <= 1'b0;
                    snz_cnt <= 4'd0;
                end else begin
                    snz_cnt <= snz_cnt - 4'd1;
                end
            end
`endif

            // NOTE: sequential state uses non-blocking assignments; the last assignment in this block wins, which sets write and set/clear priority below.
            if (we) begin
                case (address)
                    3'd0: begin
                        fired <= 1'b0;
                        err   <= 1'b0;
                    end
                    3'd1: begin
                        run      <= writedata[0];
                        alarm_en <= writedata[1];
                        irq_en   <= writedata[2];
`ifdef ALARM_RTC_SNOOZE_EN
                        if (!writedata[1]) begin
                            snz_act <= 1'b0;
                            snz_cnt <= 4'd0;
                        end
`endif
                    end
                    3'd2: begin
                        if (hm_ok(writedata)) begin
                            hours   <= writedata[15:8];
                            minutes <= writedata[7:0];
                            seconds <= 8'h00;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    3'd3: begin
                        if (ms_ok(writedata[7:0]))
                            seconds <= writedata[7:0];
                        else
                            err <= 1'b1;
                    end
                    3'd4: begin
                        if (hm_ok(writedata)) begin
                            alm_hours   <= writedata[15:8];
                            alm_minutes <= writedata[7:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
`ifdef ALARM_RTC_SNOOZE_EN
                    3'd5: begin
                        if (writedata[3:0] == 4'd0) begin
                            snz_act <= 1'b0;
                            snz_cnt <= 4'd0;
                        end else if (fired) begin
                            fired   <= 1'b0;
                            snz_act <= 1'b1;
                            snz_cnt <= writedata[3:0];
                        end
                    end
`endif
                    default: ;
                endcase
            end

            // Alarm set wins over a same-cycle STATUS clear
`ifdef ALARM_RTC_SNOOZE_EN
            if (alarm_evt || snz_fire)
                fired <= 1'b1;
`else
            if (alarm_evt)
                fired <= 1'b1;
`endif
        end
    end

endmodule
